// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream sink-side blocks.
// Holds the sink FSM state type, the ready-phase width and a saturating counter increment.
package axis_pkg;

    typedef enum logic [1:0] {
        RECV   = 2'd0,
        DRAIN  = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam int PHASE_W = 2;

    // Increments a counter of 'width' bits (width <= 32), sticking at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = 32'hFFFF_FFFF >> (32 - width);
        return (value == max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/axis_ready_gen.sv
// TREADY pattern generator: a free-running 2-bit phase selects one stall_mask bit per cycle.
// The ready output is registered one cycle ahead so it never depends on the stream inputs.
module axis_ready_gen
    import axis_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] i_stall_mask,
    input  logic       i_block_next,
    output logic       o_ready
);

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_next;
    logic               r_ready;

    assign w_phase_next = r_phase + 1'b1;

    // r_ready holds the value for the cycle in which r_phase == w_phase_next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
            r_ready <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            r_ready <= i_stall_mask[w_phase_next] && !i_block_next;
        end
    end

    assign o_ready = r_ready;

endmodule

// File: rtl/axis_packet_sink.sv
// AXI-Stream packet sink: checks packet length and data sequence, sums the payload
// and reports each packet with a one-cycle pulse plus saturating packet/error counters.
module axis_packet_sink
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int PACKET_SIZE = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int CHECK_SEQ   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic [3:0]            stall_mask,
    output logic                  pkt_done,
    output logic [DATA_WIDTH-1:0] pkt_sum,
    output logic                  pkt_len_err,
    output logic                  pkt_seq_err,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  err_count
);

    localparam int            BW        = $clog2(PACKET_SIZE);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PACKET_SIZE - 1);

    state_e                r_state;
    logic [BW-1:0]         r_beat_cnt;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_len_err;
    logic                  r_seq_err;
    logic [DATA_WIDTH-1:0] r_expected;
    logic                  r_seq_valid;

    logic                  r_pkt_done;
    logic [DATA_WIDTH-1:0] r_pkt_sum;
    logic                  r_pkt_len_err;
    logic                  r_pkt_seq_err;
    logic [CNT_WIDTH-1:0]  r_pkt_count;
    logic [CNT_WIDTH-1:0]  r_err_count;

    logic                  w_ready;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_sum_add;
    logic                  w_seq_bad;
    logic                  w_last_beat;
    logic                  w_report;
    logic [DATA_WIDTH-1:0] w_rep_sum;
    logic                  w_rep_len;
    logic                  w_rep_seq;

    axis_ready_gen u_ready_gen (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_stall_mask (stall_mask),
        .i_block_next (w_report),
        .o_ready      (w_ready)
    );

    assign w_xfer      = s_tvalid && w_ready;
    assign w_sum_add   = r_sum + s_tdata;
    assign w_seq_bad   = (CHECK_SEQ != 0) && r_seq_valid && (s_tdata != r_expected);
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);

    // The report is captured on the TLAST edge so pkt_done and its payload appear together
    // during the single REPORT cycle.
    assign w_report  = w_xfer && s_tlast && (r_state != REPORT);
    assign w_rep_sum = (r_state == RECV) ? w_sum_add : r_sum;
    assign w_rep_len = (r_state == RECV) ? !w_last_beat : r_len_err;
    assign w_rep_seq = r_seq_err || w_seq_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= RECV;
            r_beat_cnt    <= '0;
            r_sum         <= '0;
            r_len_err     <= 1'b0;
            r_seq_err     <= 1'b0;
            r_expected    <= '0;
            r_seq_valid   <= 1'b0;
            r_pkt_done    <= 1'b0;
            r_pkt_sum     <= '0;
            r_pkt_len_err <= 1'b0;
            r_pkt_seq_err <= 1'b0;
            r_pkt_count   <= '0;
            r_err_count   <= '0;
        end else begin
            r_pkt_done <= 1'b0;

            // Sequence tracking spans packet boundaries and the DRAIN state.
            if (w_xfer) begin
                r_expected  <= s_tdata + 1'b1;
                r_seq_valid <= 1'b1;
                if (w_seq_bad) begin
                    r_seq_err <= 1'b1;
                end
            end

            case (r_state)
                RECV: begin
                    if (w_xfer) begin
                        r_sum <= w_sum_add;
                        if (s_tlast) begin
                            r_state <= REPORT;
                        end else if (w_last_beat) begin
                            r_len_err <= 1'b1;
                            r_state   <= DRAIN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_xfer && s_tlast) begin
                        r_state <= REPORT;
                    end
                end
                REPORT: begin
                    r_beat_cnt <= '0;
                    r_sum      <= '0;
                    r_len_err  <= 1'b0;
                    r_seq_err  <= 1'b0;
                    r_state    <= RECV;
                end
                default: begin
                    r_state <= RECV;
                end
            endcase

            if (w_report) begin
                r_pkt_done    <= 1'b1;
                r_pkt_sum     <= w_rep_sum;
                r_pkt_len_err <= w_rep_len;
                r_pkt_seq_err <= w_rep_seq;
                r_pkt_count   <= CNT_WIDTH'(sat_inc(32'(r_pkt_count), CNT_WIDTH));
                if (w_rep_len || w_rep_seq) begin
                    r_err_count <= CNT_WIDTH'(sat_inc(32'(r_err_count), CNT_WIDTH));
                end
            end
        end
    end

    assign s_tready    = w_ready;
    assign pkt_done    = r_pkt_done;
    assign pkt_sum     = r_pkt_sum;
    assign pkt_len_err = r_pkt_len_err;
    assign pkt_seq_err = r_pkt_seq_err;
    assign pkt_count   = r_pkt_count;
    assign err_count   = r_err_count;

endmodule
